// File: rtl/q2_panel.sv
// Front-panel controller: synchronizes and debounces the switches and buttons, then
// sequences clean dep/incp/start/stop strobes, each followed by a forced-low gap.
// state | meaning
// IDLE  | waiting for a request    DEP/INCP/START/STOP | strobe high    GAP | strobes held low
module q2_panel #(
    parameter int DB_CYCLES    = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] raw_sw,
    input  logic        raw_dep,
    input  logic        raw_incp,
    input  logic        raw_start,
    input  logic        raw_stop,
    input  logic        run,
    output logic [11:0] sw,
    output logic        dep_sw,
    output logic        incp_sw,
    output logic        start_sw,
    output logic        stop_sw,
    output logic        busy
);

    localparam int DBW  = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]  GAP_LAST   = TW'(GAP_CYCLES - 1);

    // Button bit order: 0 dep, 1 incp, 2 start, 3 stop.
    localparam int B_DEP   = 0;
    localparam int B_INCP  = 1;
    localparam int B_START = 2;
    localparam int B_STOP  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEP,
        S_INCP,
        S_START,
        S_STOP,
        S_GAP
    } state_t;

    logic [11:0]    sw_sync1_q, sw_sync2_q;
    logic [3:0]     btn_sync1_q, btn_sync2_q;

    logic [3:0]     btn_lvl_q, btn_lvl_d;
    logic [3:0]     btn_prev_q;
    logic [3:0]     req_q, req_d;
    logic [DBW-1:0] btn_cnt_q [4];
    logic [DBW-1:0] btn_cnt_d [4];

    logic [11:0]    sw_samp_q;
    logic [11:0]    sw_stable_q, sw_stable_d;
    logic [DBW-1:0] sw_cnt_q, sw_cnt_d;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           auto_q, auto_d;
    logic [11:0]    sw_q, sw_d;
    logic [3:0]     strobe_q, strobe_d;
    logic           busy_q, busy_d;

    always_comb begin
        btn_lvl_d = btn_lvl_q;
        btn_cnt_d = btn_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (btn_sync2_q[i] == btn_lvl_q[i]) begin
                btn_cnt_d[i] = '0;
            end else if (btn_cnt_q[i] == DB_LAST) begin
                btn_lvl_d[i] = ~btn_lvl_q[i];
                btn_cnt_d[i] = '0;
            end else begin
                btn_cnt_d[i] = btn_cnt_q[i] + DBW'(1);
            end
        end
        // Only press edges become requests; releases are ignored.
        req_d = btn_lvl_q & ~btn_prev_q;
    end

    always_comb begin
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = sw_cnt_q;
        if (sw_sync2_q != sw_samp_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DB_LAST) begin
            sw_stable_d = sw_samp_q;
        end else begin
            sw_cnt_d = sw_cnt_q + DBW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        auto_d   = auto_q;
        sw_d     = sw_q;
        strobe_d = '0;
        busy_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_q[B_STOP]) begin
                    state_d = S_STOP;
                    tmr_d   = PULSE_LAST;
                end else if (!run) begin
                    if (req_q[B_START]) begin
                        state_d = S_START;
                        tmr_d   = PULSE_LAST;
                    end else if (req_q[B_DEP]) begin
                        state_d = S_DEP;
                        tmr_d   = PULSE_LAST;
                        auto_d  = 1'b1;
                        sw_d    = sw_stable_q;
                    end else if (req_q[B_INCP]) begin
                        state_d = S_INCP;
                        tmr_d   = PULSE_LAST;
                    end
                end
            end
            S_DEP, S_INCP, S_START, S_STOP: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    tmr_d   = GAP_LAST;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (auto_q) begin
                    // Deposit auto-advances P with a trailing incp pulse.
                    state_d = S_INCP;
                    tmr_d   = PULSE_LAST;
                    auto_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        strobe_d[B_DEP]   = (state_d == S_DEP);
        strobe_d[B_INCP]  = (state_d == S_INCP);
        strobe_d[B_START] = (state_d == S_START);
        strobe_d[B_STOP]  = (state_d == S_STOP);
        busy_d            = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
            btn_lvl_q   <= '0;
            btn_prev_q  <= '0;
            req_q       <= '0;
            for (int i = 0; i < 4; i++) btn_cnt_q[i] <= '0;
            sw_samp_q   <= '0;
            sw_stable_q <= '0;
            sw_cnt_q    <= '0;
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            auto_q      <= 1'b0;
            sw_q        <= '0;
            strobe_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            sw_sync1_q  <= raw_sw;
            sw_sync2_q  <= sw_sync1_q;
            btn_sync1_q <= {raw_stop, raw_start, raw_incp, raw_dep};
            btn_sync2_q <= btn_sync1_q;
            btn_lvl_q   <= btn_lvl_d;
            btn_prev_q  <= btn_lvl_q;
            req_q       <= req_d;
            btn_cnt_q   <= btn_cnt_d;
            sw_samp_q   <= sw_sync2_q;
            sw_stable_q <= sw_stable_d;
            sw_cnt_q    <= sw_cnt_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            auto_q      <= auto_d;
            sw_q        <= sw_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
        end
    end

    assign sw       = sw_q;
    assign dep_sw   = strobe_q[B_DEP];
    assign incp_sw  = strobe_q[B_INCP];
    assign start_sw = strobe_q[B_START];
    assign stop_sw  = strobe_q[B_STOP];
    assign busy     = busy_q;

endmodule

// File: tb/tb_q2_panel.sv
// Directed bench for q2_panel at DB_CYCLES=4, PULSE_CYCLES=4, GAP_CYCLES=2.
// Edge 0 is the first rising clock edge that samples a newly pressed raw button.
module tb_q2_panel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] raw_sw = '0;
    logic        raw_dep = 1'b0, raw_incp = 1'b0, raw_start = 1'b0, raw_stop = 1'b0;
    logic        run = 1'b0;
    logic [11:0] sw;
    logic        dep_sw, incp_sw, start_sw, stop_sw, busy;

    int vecs = 0;
    int errs = 0;

    q2_panel #(.DB_CYCLES(4), .PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .raw_sw(raw_sw),
        .raw_dep(raw_dep), .raw_incp(raw_incp), .raw_start(raw_start), .raw_stop(raw_stop),
        .run(run), .sw(sw),
        .dep_sw(dep_sw), .incp_sw(incp_sw), .start_sw(start_sw), .stop_sw(stop_sw),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        tick(3);
        vecs++;
        if ({sw, dep_sw, incp_sw, start_sw, stop_sw, busy} !== 17'd0) begin
            errs++;
            $display("FAIL reset_outputs got %h want 0", {sw, dep_sw, incp_sw, start_sw, stop_sw, busy});
        end
        rst = 1'b0;
        raw_sw = 12'hA5C;
        tick(12);
        vecs++;
        if ({sw, busy} !== 13'd0) begin
            errs++;
            $display("FAIL idle_after_reset got %h want 0", {sw, busy});
        end
    endtask

    // Expected strobe bits {dep,incp,start,stop} for a window of edges.
    task automatic test_deposit;
        logic [3:0] exp_s;
        run = 1'b0;
        raw_dep = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            tick(1);
            exp_s = 4'b0000;
            if (e >= 7 && e <= 10) exp_s = 4'b1000;
            if (e >= 13 && e <= 16) exp_s = 4'b0100;
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== exp_s || busy !== (e >= 7 && e <= 18)) begin
                errs++;
                $display("FAIL deposit_seq edge %0d got strobes %b busy %b want %b busy %b",
                         e, {dep_sw, incp_sw, start_sw, stop_sw}, busy, exp_s, (e >= 7 && e <= 18));
            end
            vecs++;
            if (sw !== ((e >= 7) ? 12'hA5C : 12'h000)) begin
                errs++;
                $display("FAIL deposit_sw edge %0d got %h want %h", e, sw, (e >= 7) ? 12'hA5C : 12'h000);
            end
        end
        raw_dep = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick(1);
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw, busy} !== 5'd0) begin
                errs++;
                $display("FAIL release_quiet cycle %0d got %b want 00000", e, {dep_sw, incp_sw, start_sw, stop_sw, busy});
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_s;
        for (int c = 0; c < 20; c++) begin
            raw_dep = ((c / 2) % 2 == 0);
            tick(1);
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw, busy} !== 5'd0) begin
                errs++;
                $display("FAIL bounce_quiet cycle %0d got %b want 00000", c, {dep_sw, incp_sw, start_sw, stop_sw, busy});
            end
        end
        raw_dep = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            tick(1);
            exp_s = 4'b0000;
            if (e >= 7 && e <= 10) exp_s = 4'b1000;
            if (e >= 13 && e <= 16) exp_s = 4'b0100;
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== exp_s) begin
                errs++;
                $display("FAIL bounce_seq edge %0d got %b want %b", e, {dep_sw, incp_sw, start_sw, stop_sw}, exp_s);
            end
        end
        raw_dep = 1'b0;
        tick(12);
    endtask

    task automatic test_lockout;
        run = 1'b1;
        for (int b = 0; b < 3; b++) begin
            raw_dep   = (b == 0);
            raw_incp  = (b == 1);
            raw_start = (b == 2);
            for (int c = 0; c < 30; c++) begin
                if (c == 15) {raw_dep, raw_incp, raw_start} = 3'b000;
                tick(1);
                vecs++;
                if ({dep_sw, incp_sw, start_sw, stop_sw, busy} !== 5'd0) begin
                    errs++;
                    $display("FAIL lockout button %0d cycle %0d got %b want 00000", b, c, {dep_sw, incp_sw, start_sw, stop_sw, busy});
                end
            end
        end
        raw_stop = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            tick(1);
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== ((e >= 7 && e <= 10) ? 4'b0001 : 4'b0000)
                || busy !== (e >= 7 && e <= 12)) begin
                errs++;
                $display("FAIL lockout_stop edge %0d got %b busy %b", e, {dep_sw, incp_sw, start_sw, stop_sw}, busy);
            end
        end
        raw_stop = 1'b0;
        run = 1'b0;
        tick(12);
    endtask

    task automatic test_simultaneous;
        raw_sw = 12'h3C3;
        tick(15);
        raw_start = 1'b1;
        raw_dep   = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            tick(1);
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== ((e >= 7 && e <= 10) ? 4'b0010 : 4'b0000)
                || busy !== (e >= 7 && e <= 12) || sw !== 12'hA5C) begin
                errs++;
                $display("FAIL simultaneous edge %0d got %b busy %b sw %h want sw a5c",
                         e, {dep_sw, incp_sw, start_sw, stop_sw}, busy, sw);
            end
        end
        raw_start = 1'b0;
        raw_dep   = 1'b0;
        tick(12);
    endtask

    task automatic test_busy_drop;
        raw_incp = 1'b1;
        for (int e = 0; e <= 26; e++) begin
            tick(1);
            if (e == 1) raw_stop = 1'b1;
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== ((e >= 7 && e <= 10) ? 4'b0100 : 4'b0000)
                || busy !== (e >= 7 && e <= 12)) begin
                errs++;
                $display("FAIL busy_drop edge %0d got %b busy %b", e, {dep_sw, incp_sw, start_sw, stop_sw}, busy);
            end
        end
        raw_incp = 1'b0;
        raw_stop = 1'b0;
        tick(12);
    endtask

    task automatic test_mid_reset;
        raw_dep = 1'b1;
        tick(9);
        vecs++;
        if (dep_sw !== 1'b1 || sw !== 12'h3C3) begin
            errs++;
            $display("FAIL mid_reset_setup got dep %b sw %h want 1 3c3", dep_sw, sw);
        end
        raw_dep = 1'b0;
        rst = 1'b1;
        #1;
        vecs++;
        if ({sw, dep_sw, incp_sw, start_sw, stop_sw, busy} !== 17'd0) begin
            errs++;
            $display("FAIL mid_reset_immediate got %h want 0", {sw, dep_sw, incp_sw, start_sw, stop_sw, busy});
        end
        tick(2);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick(1);
            vecs++;
            if ({sw, dep_sw, incp_sw, start_sw, stop_sw, busy} !== 17'd0) begin
                errs++;
                $display("FAIL mid_reset_after cycle %0d got %h want 0", c, {sw, dep_sw, incp_sw, start_sw, stop_sw, busy});
            end
        end
    endtask

    task automatic test_held_reset;
        raw_incp = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            tick(1);
            vecs++;
            if ({dep_sw, incp_sw, start_sw, stop_sw} !== ((e >= 7 && e <= 10) ? 4'b0100 : 4'b0000)
                || busy !== (e >= 7 && e <= 12)) begin
                errs++;
                $display("FAIL held_reset edge %0d got %b busy %b", e, {dep_sw, incp_sw, start_sw, stop_sw}, busy);
            end
        end
        raw_incp = 1'b0;
        tick(10);
    endtask

    initial begin
        test_reset;
        test_deposit;
        test_bounce;
        test_lockout;
        test_simultaneous;
        test_busy_drop;
        test_mid_reset;
        test_held_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/q2_panel.md
Q2_PANEL -- requirements
Module: q2_panel

Interface
REQ-001 Parameter DB_CYCLES, default 16, number of consecutive stable cycles required before a debounced level changes.
REQ-002 Parameter PULSE_CYCLES, default 4, high width of every generated strobe.
REQ-003 Parameter GAP_CYCLES, default 2, forced-low time after every strobe.
REQ-004 clk  in  1  the single clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 raw_sw  in  12  raw data switches, asynchronous and bouncy.
REQ-007 raw_dep, raw_incp, raw_start, raw_stop  in  1 each  raw push-buttons, active-high, asynchronous and bouncy.
REQ-008 run  in  1  processor run status.
REQ-009 sw  out  12  latched deposit value.
REQ-010 dep_sw, incp_sw, start_sw, stop_sw  out  1 each  clean strobes.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Every raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each button SHALL have its own debounce counter and debounced level:
- The counter clears on any cycle where the synced input equals the debounced level.
- The debounced level toggles, and the counter clears, on the edge where the input has differed for DB_CYCLES consecutive edges.
REQ-014 raw_sw SHALL use one shared 12-bit debouncer:
- The stable value updates only after the synced vector is unchanged for DB_CYCLES consecutive edges.
- Any bit change restarts the count.
REQ-015 A request SHALL be a 0->1 transition of a debounced button level; releases generate nothing.
REQ-016 FSM states SHALL be IDLE, DEP, INCP, START, STOP, GAP; each strobe state holds its output high for exactly PULSE_CYCLES cycles.
REQ-017 Requests SHALL be accepted only in IDLE; requests arriving in any other state are dropped, not queued.
REQ-018 Priority for same-cycle requests SHALL be stop > start > dep > incp; lower-priority requests in that cycle are dropped.
REQ-019 A stop request SHALL always be accepted: IDLE -> STOP -> GAP -> IDLE.
REQ-020 A start request SHALL be accepted only when run=0: START -> GAP -> IDLE; it is dropped when run=1.
REQ-021 Dep and incp requests SHALL be dropped when run=1.
REQ-022 An accepted dep request SHALL:
- latch the debounced switch value into sw on the acceptance edge;
- then sequence DEP -> GAP -> INCP -> GAP -> IDLE (deposit with auto-advance of P).
REQ-023 An accepted incp request SHALL sequence INCP -> GAP -> IDLE; sw is unchanged.
REQ-024 GAP SHALL hold all strobes low for exactly GAP_CYCLES cycles.
REQ-025 The strobes SHALL be registered outputs and mutually exclusive; at most one is high in any cycle.
REQ-026 sw SHALL change only on dep acceptance or reset.
REQ-027 With the FSM idle, the first strobe cycle SHALL occur DB_CYCLES+3 edges after the first edge that samples the raw button high.
REQ-028 A change in run during a sequence SHALL NOT abort it; run is checked only at acceptance.

Reset
REQ-029 While rst=1, the following SHALL be 0: all synchronizers, debounced levels, counters, sw, all strobes and busy; the FSM SHALL be in IDLE.
REQ-030 Reset asserted mid-sequence SHALL immediately force all strobes low; no strobe resumes after release.
REQ-031 A button held through reset release SHALL produce one request, after DB_CYCLES+3 edges.

Verification (DB_CYCLES=4, PULSE_CYCLES=4, GAP_CYCLES=2)
REQ-032 Deposit: raw_sw=12'hA5C, run=0, clean raw_dep press -> sw=12'hA5C on the acceptance edge. Then:
- dep_sw high for 4 cycles starting at edge 7, then low for 2;
- incp_sw high for 4, then low for 2;
- busy=0 after.
REQ-033 Bounce: raw_dep toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one dep sequence, starting 7 edges after the final rising edge.
REQ-034 Lockout: run=1, press dep, incp, then start -> no strobes. Then press stop -> stop_sw high for 4 cycles.
REQ-035 Simultaneous: raw_start and raw_dep rise in the same cycle with run=0 -> only start_sw pulses, sw unchanged.
REQ-036 Busy drop: press incp, then press stop during the INCP state -> incp sequence completes, stop is dropped.
REQ-037 Mid-operation reset: rst pulsed during the DEP state -> dep_sw=0 and sw=0 immediately, no incp_sw follows, busy=0.
